// File: rtl/accum_post_adder.sv
`default_nettype none
// ============================================================================
// accum_post_adder : X/Z-mux post-adder/subtractor with optional P register
// Revision 1.0
// ============================================================================
module accum_post_adder #(
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic        CEP,
  input  logic [4:0]  OPMODE,
  input  logic [35:0] M,
  input  logic [47:0] DAB,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic        CIN,
  input  logic        IN_VALID,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        OUT_VALID
);

  localparam logic [1:0] c_X_ZERO = 2'b00;
  localparam logic [1:0] c_X_M    = 2'b01;
  localparam logic [1:0] c_X_P    = 2'b10;
  localparam logic [1:0] c_X_DAB  = 2'b11;

  localparam logic [1:0] c_Z_ZERO = 2'b00;
  localparam logic [1:0] c_Z_PCIN = 2'b01;
  localparam logic [1:0] c_Z_P    = 2'b10;
  localparam logic [1:0] c_Z_C    = 2'b11;

  logic [47:0] w_m_ext;
  logic [47:0] w_fb;
  logic [47:0] w_x;
  logic [47:0] w_z;
  logic [48:0] w_x_cin;
  logic [48:0] w_sum;
  logic [47:0] w_p;
  logic        w_carry;
  logic        w_valid;

  assign w_m_ext = {{12{M[35]}}, M};

  always_comb begin
    w_x = 48'd0;
    case (OPMODE[1:0])
      c_X_ZERO: w_x = 48'd0;
      c_X_M:    w_x = w_m_ext;
      c_X_P:    w_x = w_fb;
      c_X_DAB:  w_x = DAB;
      default:  w_x = 48'd0;
    endcase
  end

  always_comb begin
    w_z = 48'd0;
    case (OPMODE[3:2])
      c_Z_ZERO: w_z = 48'd0;
      c_Z_PCIN: w_z = PCIN;
      c_Z_P:    w_z = w_fb;
      c_Z_C:    w_z = C;
      default:  w_z = 48'd0;
    endcase
  end

  // Carry-in folds into X first so subtraction computes Z - (X + CIN); bit 48 is the borrow.
  assign w_x_cin = {1'b0, w_x} + {48'd0, CIN};
  assign w_sum   = OPMODE[4] ? ({1'b0, w_z} - w_x_cin) : ({1'b0, w_z} + w_x_cin);

  generate
    if (PREG != 0) begin : g_preg
      logic [47:0] r_p;
      logic        r_valid;

      always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
          r_p     <= 48'd0;
          r_valid <= 1'b0;
        end else if (CEP) begin
          r_p     <= w_sum[47:0];
          r_valid <= IN_VALID;
        end
      end

      assign w_fb    = r_p;
      assign w_p     = r_p;
      assign w_valid = r_valid;

      if (CARRYOUTREG != 0) begin : g_carry_reg
        logic r_carry;

        always_ff @(posedge clk or negedge RST_N) begin
          if (!RST_N) begin
            r_carry <= 1'b0;
          end else if (CEP) begin
            r_carry <= w_sum[48];
          end
        end

        assign w_carry = r_carry;
      end else begin : g_carry_comb
        assign w_carry = w_sum[48];
      end
    end else begin : g_pcomb
      // Feedback is tied off so the combinational path cannot loop through P.
      assign w_fb    = 48'd0;
      assign w_p     = w_sum[47:0];
      assign w_carry = w_sum[48];
      assign w_valid = IN_VALID;
    end
  endgenerate

  assign P         = w_p;
  assign PCOUT     = w_p;
  assign CARRYOUT  = w_carry;
  assign OUT_VALID = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_accum_post_adder.sv
`default_nettype none
// ============================================================================
// tb_accum_post_adder : scoreboard bench for three parameterisations
// Revision 1.0
// ============================================================================
module tb_accum_post_adder;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        CEP;
  logic [4:0]  OPMODE;
  logic [35:0] M;
  logic [47:0] DAB, C, PCIN;
  logic        CIN, IN_VALID;

  logic [47:0] p_a, pc_a, p_b, pc_b, p_c, pc_c;
  logic        co_a, ov_a, co_b, ov_b, co_c, ov_c;

  int checks = 0;
  int errors = 0;

  logic [49:0] exp_q[$];
  logic [47:0] model_p;
  logic [49:0] held;

  always #5 clk = ~clk;

  accum_post_adder #(.PREG(1), .CARRYOUTREG(1)) u_dut_reg (
    .clk(clk), .RST_N(RST_N), .CEP(CEP), .OPMODE(OPMODE), .M(M), .DAB(DAB),
    .C(C), .PCIN(PCIN), .CIN(CIN), .IN_VALID(IN_VALID),
    .P(p_a), .PCOUT(pc_a), .CARRYOUT(co_a), .OUT_VALID(ov_a));

  accum_post_adder #(.PREG(1), .CARRYOUTREG(0)) u_dut_cr0 (
    .clk(clk), .RST_N(RST_N), .CEP(CEP), .OPMODE(OPMODE), .M(M), .DAB(DAB),
    .C(C), .PCIN(PCIN), .CIN(CIN), .IN_VALID(IN_VALID),
    .P(p_b), .PCOUT(pc_b), .CARRYOUT(co_b), .OUT_VALID(ov_b));

  accum_post_adder #(.PREG(0), .CARRYOUTREG(1)) u_dut_comb (
    .clk(clk), .RST_N(RST_N), .CEP(CEP), .OPMODE(OPMODE), .M(M), .DAB(DAB),
    .C(C), .PCIN(PCIN), .CIN(CIN), .IN_VALID(IN_VALID),
    .P(p_c), .PCOUT(pc_c), .CARRYOUT(co_c), .OUT_VALID(ov_c));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick operands by selector value, then do plain 49-bit arithmetic.
  function automatic logic [48:0] ref_sum(input logic [4:0] op, input logic [35:0] m,
                                          input logic [47:0] dab, input logic [47:0] c,
                                          input logic [47:0] pcin, input logic cin,
                                          input logic [47:0] fb);
    longint      sm;
    logic [63:0] smu;
    logic [48:0] x, z, cin49;
    sm  = longint'($signed(m));
    smu = sm;
    x = (op[1:0] == 2'd0) ? 49'd0 : (op[1:0] == 2'd1) ? {1'b0, smu[47:0]} :
        (op[1:0] == 2'd2) ? {1'b0, fb} : {1'b0, dab};
    z = (op[3:2] == 2'd0) ? 49'd0 : (op[3:2] == 2'd1) ? {1'b0, pcin} :
        (op[3:2] == 2'd2) ? {1'b0, fb} : {1'b0, c};
    cin49 = {48'd0, cin};
    return op[4] ? (z - (x + cin49)) : (z + x + cin49);
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0];
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input logic [4:0] op, input logic [35:0] m, input logic [47:0] dab,
                       input logic [47:0] c, input logic [47:0] pcin, input logic cin,
                       input logic inv, input logic cep);
    logic [48:0] s_reg, s_comb;
    OPMODE = op; M = m; DAB = dab; C = c; PCIN = pcin; CIN = cin;
    IN_VALID = inv; CEP = cep;
    #1;
    s_comb = ref_sum(op, m, dab, c, pcin, cin, 48'd0);
    s_reg  = ref_sum(op, m, dab, c, pcin, cin, model_p);
    chk("comb_p", p_c, s_comb[47:0]);
    chk("comb_pcout", pc_c, s_comb[47:0]);
    chk("comb_carry", co_c, s_comb[48]);
    chk("comb_valid", ov_c, inv);
    chk("cr0_comb_carry", co_b, s_reg[48]);
    if (cep) begin
      model_p = s_reg[47:0];
      exp_q.push_back({inv, s_reg[48], s_reg[47:0]});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    CEP   = 1'b0;
    #1;
    chk("rst_p", p_a, 48'd0);
    chk("rst_pcout", pc_a, 48'd0);
    chk("rst_carry", co_a, 1'b0);
    chk("rst_valid", ov_a, 1'b0);
    chk("rst_cr0_p", p_b, 48'd0);
    chk("rst_cr0_valid", ov_b, 1'b0);
    model_p = 48'd0;
    exp_q.delete();
    @(negedge clk);
    RST_N = 1'b1;
  endtask

  // Monitor: each enabled edge pops one expectation; disabled edges must hold it.
  initial begin
    logic rst_s, cep_s;
    held = '0;
    forever begin
      @(posedge clk);
      rst_s = RST_N;
      cep_s = CEP;
      #1;
      if (!rst_s) begin
        held = '0;
      end else if (cep_s) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow actual=empty expected=entry at %0t", $time);
        end else begin
          held = exp_q.pop_front();
        end
      end
      chk("mon_p", p_a, held[47:0]);
      chk("mon_pcout", pc_a, held[47:0]);
      chk("mon_carry", co_a, held[48]);
      chk("mon_valid", ov_a, held[49]);
      chk("mon_cr0_p", p_b, held[47:0]);
      chk("mon_cr0_pcout", pc_b, held[47:0]);
      chk("mon_cr0_valid", ov_b, held[49]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  op;
    logic [35:0] m;
    logic [47:0] t;
    model_p  = 48'd0;
    RST_N    = 1'b0;
    CEP      = 1'b0;
    OPMODE   = 5'd0;
    M        = 36'd0;
    DAB      = 48'd0;
    C        = 48'd0;
    PCIN     = 48'd0;
    CIN      = 1'b0;
    IN_VALID = 1'b0;
    #2;
    chk("init_p", p_a, 48'd0);
    chk("init_carry", co_a, 1'b0);
    chk("init_valid", ov_a, 1'b0);
    @(negedge clk);
    RST_N = 1'b1;

    for (int i = 0; i < 4; i++)
      drive(5'b01001, 36'd5, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1);
    chk("acc_20", p_a, 48'd20);

    for (int i = 0; i < 3; i++)
      drive(5'b01001, 36'd7 + 36'(i), 48'd0, 48'd0, 48'd0, 1'b0, 1'b0, 1'b0);
    chk("cep_hold_p", p_a, 48'd20);
    chk("cep_hold_valid", ov_a, 1'b1);
    for (int i = 0; i < 2; i++)
      drive(5'b01001, 36'd5, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1);
    chk("cep_resume", p_a, 48'd30);

    drive(5'b00011, 36'd0, 48'h123, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1);
    chk("preload", p_a, 48'h123);
    do_reset();
    drive(5'b01001, 36'd5, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1);
    chk("post_reset_acc", p_a, 48'd5);

    drive(5'b11111, 36'd0, 48'd5, 48'd3, 48'd0, 1'b0, 1'b1, 1'b1);
    chk("sub_p", p_a, 48'hFFFF_FFFF_FFFE);
    chk("sub_borrow", co_a, 1'b1);

    drive(5'b01111, 36'd0, 48'd1, 48'hFFFF_FFFF_FFFF, 48'd0, 1'b0, 1'b1, 1'b1);
    chk("wrap_p", p_a, 48'd0);
    chk("wrap_carry", co_a, 1'b1);

    drive(5'b00001, 36'hF_FFFF_FFFF, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1);
    chk("sext_comb_p", p_c, 48'hFFFF_FFFF_FFFF);
    chk("sext_comb_valid", ov_c, 1'b1);
    chk("sext_reg_p", p_a, 48'hFFFF_FFFF_FFFF);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        op = 5'($urandom);
        t  = rnd48();
        m  = t[35:0];
        if ($urandom_range(0, 7) == 0) m = 36'hF_FFFF_FFFF;
        drive(op, m, rnd48(), ($urandom_range(0, 5) == 0) ? 48'hFFFF_FFFF_FFFF : rnd48(),
              rnd48(), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      end
    end

    for (int i = 0; i < 3; i++)
      drive(5'b00000, 36'd0, 48'd0, 48'd0, 48'd0, 1'b0, 1'b0, 1'b0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
